// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the memory copy controller.
//   copy_state_t : FSM state encoding
//   ADDR_W_DEF   : default memory address width
//   DATA_W_DEF   : default memory data width
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_if.sv
// Handshake and memory bus bundle for mem_copy_ctrl.
//   Control side : start, src_addr, dst_addr, len (to controller); busy, done (from controller)
//   Memory side  : mem_we, mem_addr, mem_wdata (from controller); mem_rdata (to controller)
//   chk_sum      : only with MEM_COPY_CHECKSUM_EN defined
// Modports:
//   master : the copy controller (initiator on the memory bus)
//   slave  : host control logic plus the memory it talks to
interface mem_copy_if #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_copy_pkg::DATA_W_DEF
) ();

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] chk_sum;

  modport master (
    input  start, src_addr, dst_addr, len, mem_rdata,
    output busy, done, mem_we, mem_addr, mem_wdata, chk_sum
  );

  modport slave (
    output start, src_addr, dst_addr, len, mem_rdata,
    input  busy, done, mem_we, mem_addr, mem_wdata, chk_sum
  );
`else
  modport master (
    input  start, src_addr, dst_addr, len, mem_rdata,
    output busy, done, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, src_addr, dst_addr, len, mem_rdata,
    input  busy, done, mem_we, mem_addr, mem_wdata
  );
`endif

endinterface

// File: rtl/mem_copy_ctrl.sv
// Byte-copy initiator for a single-port memory with 1-cycle read latency.
// Copies len bytes from src_addr to dst_addr as alternating read/write cycles,
// with a start/busy/done handshake towards the host.
// Ports:
//   clk_i  : clock, all state updates on rising edge
//   rst_i  : asynchronous active-high reset
//   bus_if : mem_copy_if.master (control handshake + memory bus)
// Optional feature macro: MEM_COPY_CHECKSUM_EN adds a running byte sum (chk_sum)
// of all data written during a copy.
//
// state | meaning
// IDLE  | waiting for start; memory bus quiet
// RD    | drive source address src+idx
// WR    | write returned byte to dst+idx
// DONE  | one-cycle completion pulse
module mem_copy_ctrl
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mem_copy_if.master bus_if
);

  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          src_d   = bus_if.src_addr;
          dst_d   = bus_if.dst_addr;
          len_d   = bus_if.len;
          idx_d   = '0;
          state_d = (bus_if.len != '0) ? RD : DONE;
        end
      end
      RD: begin
        // Address sums wrap naturally at the address width.
        mem_addr = src_q + idx_q;
        state_d  = WR;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = dst_q + idx_q;
        mem_wdata = bus_if.mem_rdata;
        if (idx_q == len_q - IDX_ONE) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = RD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_if.busy      = (state_q != IDLE);
  assign bus_if.done      = done;
  assign bus_if.mem_we    = mem_we;
  assign bus_if.mem_addr  = mem_addr;
  assign bus_if.mem_wdata = mem_wdata;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] chk_sum_q, chk_sum_d;

  // Sum is cleared only on an accepted start so the final value survives
  // through DONE and IDLE until the next copy begins.
  always_comb begin
    chk_sum_d = chk_sum_q;
    if (state_q == IDLE && bus_if.start) begin
      chk_sum_d = '0;
    end else if (state_q == WR) begin
      chk_sum_d = chk_sum_q + bus_if.mem_rdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chk_sum_q <= '0;
    end else begin
      chk_sum_q <= chk_sum_d;
    end
  end

  assign bus_if.chk_sum = chk_sum_q;
`endif

endmodule
